// File: rtl/operand_ramp_if.sv
// Bus between the ramp generator, its command source and the adder operand sink.
// Valid/ready: a transfer happens on a rising edge where valid && ready. The sender holds valid and payload stable until that edge. Ready may change at any time.
interface operand_ramp_if #(parameter int CNT_W = 16);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a_start;
  logic [31:0]      cmd_a_step;
  logic [31:0]      cmd_b_start;
  logic [31:0]      cmd_b_step;
  logic [CNT_W-1:0] cmd_count;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_a;
  logic [31:0]      out_b;
  logic             seg_done;
  logic             busy;

  modport master (
    output cmd_valid, cmd_a_start, cmd_a_step, cmd_b_start, cmd_b_step, cmd_count, out_ready,
    input  cmd_ready, out_valid, out_a, out_b, seg_done, busy
  );

  modport slave (
    input  cmd_valid, cmd_a_start, cmd_a_step, cmd_b_start, cmd_b_step, cmd_count, out_ready,
    output cmd_ready, out_valid, out_a, out_b, seg_done, busy
  );
endinterface

// File: rtl/operand_ramp_gen.sv
// Segment-queued linear ramp generator feeding the a/b operands of the 32-bit sum adder.
// Each queued command emits count pairs (start + k*step), with back-to-back segments chained without bubbles.
module operand_ramp_gen #(
  parameter int CMD_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          reset,
  operand_ramp_if.slave bus,
  output logic [1:0]    dbg_state_o
);
  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      a_start;
    logic [31:0]      a_step;
    logic [31:0]      b_start;
    logic [31:0]      b_step;
    logic [CNT_W-1:0] count;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRIME = 2'd1, S_RUN = 2'd2} state_t;

  cmd_t             mem_q [CMD_DEPTH];
  cmd_t             head;
  cmd_t             push_cmd;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  state_t           state_q, state_d;
  logic [31:0]      a_q, b_q, a_step_q, b_step_q;
  logic [CNT_W-1:0] rem_q;
  logic             out_valid_q, seg_done_q, busy_q, busy_d;
  logic             push, pop, beat, last_beat, head_ok;

  assign push_cmd  = {bus.cmd_a_start, bus.cmd_a_step, bus.cmd_b_start, bus.cmd_b_step, bus.cmd_count};
  assign head      = mem_q[rd_ptr_q];
  assign head_ok   = (occ_q != '0);
  assign bus.cmd_ready = (occ_q != OCC_W'(CMD_DEPTH));
  assign push      = bus.cmd_valid && bus.cmd_ready;
  assign beat      = (state_q == S_RUN) && out_valid_q && bus.out_ready;
  assign last_beat = beat && (rem_q == CNT_W'(1));

  // A zero-count head is never chained from RUN; it goes through IDLE so its seg_done gets its own cycle.
  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (head_ok) begin
          pop = 1'b1;
          if (head.count != '0) state_d = S_PRIME;
        end
      end
      S_PRIME: state_d = S_RUN;
      S_RUN: begin
        if (last_beat) begin
          if (head_ok && (head.count != '0)) pop = 1'b1;
          else                               state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    occ_d  = occ_q + OCC_W'(push) - OCC_W'(pop);
    busy_d = (state_d != S_IDLE) || (occ_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_cmd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      a_step_q    <= '0;
      b_step_q    <= '0;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      seg_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      busy_q     <= busy_d;
      seg_done_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            if (head.count == '0) begin
              seg_done_q <= 1'b1;
            end else begin
              a_q      <= head.a_start;
              b_q      <= head.b_start;
              a_step_q <= head.a_step;
              b_step_q <= head.b_step;
              rem_q    <= head.count;
            end
          end
        end
        S_PRIME: out_valid_q <= 1'b1;
        S_RUN: begin
          if (last_beat) begin
            seg_done_q <= 1'b1;
            if (pop) begin
              a_q      <= head.a_start;
              b_q      <= head.b_start;
              a_step_q <= head.a_step;
              b_step_q <= head.b_step;
              rem_q    <= head.count;
            end else begin
              out_valid_q <= 1'b0;
            end
          end else if (beat) begin
            a_q   <= a_q + a_step_q;
            b_q   <= b_q + b_step_q;
            rem_q <= rem_q - CNT_W'(1);
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.seg_done  = seg_done_q;
  assign bus.busy      = busy_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_operand_ramp_gen.sv
// Bench for operand_ramp_gen: expected pairs come from start + k*step arithmetic, consumed by a negedge monitor.
module tb_operand_ramp_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  dbg_state;
  int          n_tests = 0;
  int          n_fail = 0;
  int          rdy_mode = 1;   // 0: hold off, 1: always ready, 2: random 50 %
  logic [64:0] exp_q[$];       // {last_of_segment, a, b}
  logic [63:0] done_q[$];      // last pair seen before each seg_done pulse
  int          beat_cnt = 0;
  int          done_pulses = 0;
  logic        exp_done_pend = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] hold_a = '0, hold_b = '0, last_a = '0, last_b = '0;

  operand_ramp_if #(.CNT_W(16)) rif();

  operand_ramp_gen #(.CMD_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(rif), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- out_ready driver ----------------
  initial begin
    rif.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rif.out_ready = 1'b0;
        1:       rif.out_ready = 1'b1;
        default: rif.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_tests++;
        if (rif.out_valid !== 1'b1 || rif.out_a !== hold_a || rif.out_b !== hold_b) begin
          n_fail++; $display("FAIL stall_hold: got v=%b a=%h b=%h required v=1 a=%h b=%h", rif.out_valid, rif.out_a, rif.out_b, hold_a, hold_b);
        end
      end
      if (exp_done_pend) begin
        n_tests++;
        if (rif.seg_done !== 1'b1) begin n_fail++; $display("FAIL seg_done_after_last: got %b required 1", rif.seg_done); end
        exp_done_pend = 1'b0;
      end
      if (rif.seg_done === 1'b1) begin
        done_pulses++;
        done_q.push_back({last_a, last_b});
      end
      if (rif.out_valid === 1'b1 && rif.out_ready === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL unexpected_beat: got a=%h b=%h required no beat", rif.out_a, rif.out_b);
        end else begin
          e = exp_q.pop_front();
          if ({rif.out_a, rif.out_b} !== e[63:0]) begin
            n_fail++; $display("FAIL beat_value: got a=%h b=%h required a=%h b=%h", rif.out_a, rif.out_b, e[63:32], e[31:0]);
          end
          if (e[64]) exp_done_pend = 1'b1;
        end
        last_a = rif.out_a;
        last_b = rif.out_b;
        beat_cnt++;
      end
      stall_prev = (rif.out_valid === 1'b1) && (rif.out_ready === 1'b0);
      hold_a = rif.out_a;
      hold_b = rif.out_b;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [31:0] a0, input logic [31:0] as, input logic [31:0] b0, input logic [31:0] bs, input logic [15:0] cnt);
    int g = 0;
    int n = int'(cnt);
    logic [31:0] av, bv;
    rif.cmd_a_start = a0; rif.cmd_a_step = as;
    rif.cmd_b_start = b0; rif.cmd_b_step = bs;
    rif.cmd_count = cnt;  rif.cmd_valid = 1'b1;
    while (rif.cmd_ready !== 1'b1 && g < 2000) begin @(posedge clk); #1; g++; end
    if (g >= 2000) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: cmd_ready got %b required 1", rif.cmd_ready);
      rif.cmd_valid = 1'b0;
      return;
    end
    for (int k = 0; k < n; k++) begin
      av = a0 + as * 32'(k);
      bv = b0 + bs * 32'(k);
      exp_q.push_back({(k == n - 1), av, bv});
    end
    @(posedge clk); #1;
    rif.cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int g = 0;
    while ((exp_q.size() != 0 || rif.busy !== 1'b0 || rif.out_valid !== 1'b0) && g < budget) begin
      @(posedge clk); #1; g++;
    end
    n_tests++;
    if (g >= budget) begin n_fail++; $display("FAIL drain_timeout: got %0d beats pending required 0", exp_q.size()); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (rif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", rif.out_valid); end
    n_tests++; if ({rif.out_a, rif.out_b} !== 64'd0) begin n_fail++; $display("FAIL reset_out_ab: got %h/%h required 0/0", rif.out_a, rif.out_b); end
    n_tests++; if (rif.seg_done !== 1'b0) begin n_fail++; $display("FAIL reset_seg_done: got %b required 0", rif.seg_done); end
    n_tests++; if (rif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", rif.busy); end
    n_tests++; if (rif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 1", rif.cmd_ready); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (rif.out_valid !== 1'b0 || rif.busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got v=%b busy=%b required 0/0", rif.out_valid, rif.busy); end
  endtask

  task automatic test_down_up();
    int d0 = done_pulses;
    logic [63:0] got;
    rdy_mode = 1;
    done_q.delete();
    push_cmd(32'd0, 32'd1, 32'd100, 32'hFFFF_FFFF, 16'd101);
    n_tests++; if (rif.busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_push: got %b required 1", rif.busy); end
    wait_drain(2000);
    n_tests++; if (done_pulses - d0 != 1) begin n_fail++; $display("FAIL down_up_done_count: got %0d required 1", done_pulses - d0); end
    got = (done_q.size() > 0) ? done_q[0] : 64'd0;
    n_tests++; if (got !== {32'd100, 32'd0}) begin n_fail++; $display("FAIL down_up_last: got %h required %h", got, {32'd100, 32'd0}); end
  endtask

  task automatic test_step4_wide();
    int d0 = done_pulses;
    int bubbles = 0;
    int g = 0;
    bit started = 0;
    logic [63:0] got0, got1;
    rdy_mode = 1;
    done_q.delete();
    push_cmd(32'd127, 32'd4, 32'd127, 32'd4, 16'd33);
    push_cmd(32'h3FF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 16'd13108);
    while (exp_q.size() > 0 && g < 20000) begin
      @(posedge clk); #1; g++;
      if (rif.out_valid === 1'b1) started = 1;
      else if (started && exp_q.size() > 1) bubbles++;
    end
    wait_drain(2000);
    n_tests++; if (bubbles != 0) begin n_fail++; $display("FAIL chain_bubbles: got %0d required 0", bubbles); end
    n_tests++; if (done_pulses - d0 != 2) begin n_fail++; $display("FAIL chain_done_count: got %0d required 2", done_pulses - d0); end
    got0 = (done_q.size() > 0) ? done_q[0] : 64'd0;
    got1 = (done_q.size() > 1) ? done_q[1] : 64'd0;
    n_tests++; if (got0 !== {32'd255, 32'd255}) begin n_fail++; $display("FAIL step4_last: got %h required %h", got0, {32'd255, 32'd255}); end
    n_tests++; if (got1 !== {32'h0001_03FE, 32'hFFF9_999F}) begin n_fail++; $display("FAIL wide_last: got %h required %h", got1, {32'h0001_03FE, 32'hFFF9_999F}); end
  endtask

  task automatic test_wrap();
    int d0 = done_pulses;
    logic [63:0] got;
    rdy_mode = 1;
    done_q.delete();
    push_cmd(32'hFFFF_FFFE, 32'd1, 32'd1, 32'hFFFF_FFFF, 16'd3);
    wait_drain(200);
    n_tests++; if (done_pulses - d0 != 1) begin n_fail++; $display("FAIL wrap_done_count: got %0d required 1", done_pulses - d0); end
    got = (done_q.size() > 0) ? done_q[0] : 64'd0;
    n_tests++; if (got !== {32'd0, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL wrap_last: got %h required %h", got, {32'd0, 32'hFFFF_FFFF}); end
  endtask

  task automatic test_backpressure();
    int d0 = done_pulses;
    rdy_mode = 2;
    for (int i = 0; i < 6; i++)
      push_cmd($urandom, $urandom, $urandom, $urandom, 16'($urandom_range(1, 12)));
    push_cmd(32'd0, 32'd1, 32'd100, 32'hFFFF_FFFF, 16'd101);
    wait_drain(5000);
    n_tests++; if (done_pulses - d0 != 7) begin n_fail++; $display("FAIL random_done_count: got %0d required 7", done_pulses - d0); end

    d0 = done_pulses;
    rdy_mode = 0;
    push_cmd(32'd10, 32'd1, 32'd20, 32'd1, 16'd4);
    repeat (3) @(posedge clk);
    #1;
    push_cmd(32'd500, 32'd0, 32'd600, 32'd0, 16'd0);
    n_tests++; if (rif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL one_queued_ready: got %b required 1", rif.cmd_ready); end
    push_cmd(32'd30, 32'd2, 32'd40, 32'd3, 16'd3);
    n_tests++; if (rif.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b required 0", rif.cmd_ready); end
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (rif.cmd_ready !== 1'b0 || rif.out_valid !== 1'b1) begin n_fail++; $display("FAIL full_stalled: got ready=%b valid=%b required 0/1", rif.cmd_ready, rif.out_valid); end
    rdy_mode = 2;
    push_cmd(32'd7, 32'd7, 32'd8, 32'd8, 16'd2);
    wait_drain(2000);
    n_tests++; if (done_pulses - d0 != 4) begin n_fail++; $display("FAIL full_done_count: got %0d required 4", done_pulses - d0); end
  endtask

  task automatic test_reset_mid();
    int b0, d0;
    int g = 0;
    rdy_mode = 1;
    b0 = beat_cnt;
    push_cmd(32'd0, 32'd1, 32'd100, 32'hFFFF_FFFF, 16'd101);
    push_cmd(32'd5, 32'd5, 32'd5, 32'd5, 16'd4);
    while (beat_cnt - b0 < 9 && g < 500) begin @(posedge clk); #1; g++; end
    n_tests++; if (beat_cnt - b0 < 9) begin n_fail++; $display("FAIL mid_beats_timeout: got %0d required 9", beat_cnt - b0); end
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    exp_done_pend = 1'b0;
    n_tests++; if (rif.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b required 0", rif.out_valid); end
    n_tests++; if (rif.busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b required 0", rif.busy); end
    n_tests++; if (rif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b required 1", rif.cmd_ready); end
    reset = 1'b0;
    d0 = done_pulses;
    b0 = beat_cnt;
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if (done_pulses != d0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d pulses required 0", done_pulses - d0); end
    n_tests++; if (beat_cnt != b0) begin n_fail++; $display("FAIL mid_reset_flushed: got %0d beats required 0", beat_cnt - b0); end
    push_cmd(32'h1234, 32'd3, 32'h42, 32'hFFFF_FFFE, 16'd5);
    n_tests++; if (rif.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge_n: got %b required 0", rif.out_valid); end
    @(posedge clk); #1;
    n_tests++; if (rif.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_edge_n1: got %b required 0", rif.out_valid); end
    @(posedge clk); #1;
    n_tests++; if (rif.out_valid !== 1'b1 || rif.out_a !== 32'h1234) begin n_fail++; $display("FAIL lat_edge_n2: got v=%b a=%h required v=1 a=00001234", rif.out_valid, rif.out_a); end
    wait_drain(200);
    n_tests++; if (done_pulses - d0 != 1) begin n_fail++; $display("FAIL fresh_done_count: got %0d required 1", done_pulses - d0); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rif.cmd_valid = 1'b0;
    rif.cmd_a_start = '0; rif.cmd_a_step = '0;
    rif.cmd_b_start = '0; rif.cmd_b_step = '0;
    rif.cmd_count = '0;
    test_reset();
    test_down_up();
    test_step4_wide();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_beats: got %0d required 0", exp_q.size()); end
    $display("[TB] final fsm state code %0d", dbg_state);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: got no completion required completion before 3 ms");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
